hazard_stall_ctrl: RTL and testbench

// - Decode-stage consumer of the 3-deep destination-register history (EX/MEM/WB producers).
// - Compares decode source regs against history; drives operand-forward selects, and

---
 rtl/cpu_hazard_pkg.sv | 26 ++
 rtl/hazard_match.sv | 51 +++++
 rtl/hazard_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_hazard_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_hazard_pkg: forward-select encodings, history fields, FSM states |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

  // History entries are {is_load, dst}; the load flag sits just above the index.
  function automatic int is_load_bit(input int reg_w);
    return reg_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// +--------------------------------------------------------------------+
// | hazard_match: one decode source against the EX/MEM/WB history       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_match
  import cpu_hazard_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  logic [REG_W:0]   hist1_i,
  input  logic [REG_W:0]   hist2_i,
  input  logic [REG_W:0]   hist3_i,
  output logic             match1_o,
  output logic             match2_o,
  output logic             load1_o,
  output logic [1:0]       fwd_o
);

  localparam int IS_LOAD_BIT = is_load_bit(REG_W);

  logic w_live;
  logic w_match3;

  // r0 is hardwired zero, so neither a zero source nor a zero dst can alias.
  assign w_live   = use_i && (src_i != '0);
  assign match1_o = w_live && (hist1_i[REG_W-1:0] == src_i);
  assign match2_o = w_live && (hist2_i[REG_W-1:0] == src_i);
  assign w_match3 = w_live && (hist3_i[REG_W-1:0] == src_i);
  assign load1_o  = hist1_i[IS_LOAD_BIT];

  always_comb begin
    fwd_o = FWD_RF;
    if (FWD_EN != 0) begin
      if (match1_o) begin
        fwd_o = load1_o ? FWD_RF : FWD_EX;
      end else if (match2_o) begin
        fwd_o = FWD_MEM;
      end else if (w_match3) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// +--------------------------------------------------------------------+
// | hazard_stall_ctrl: decode RAW hazard forwarding and stall control   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_stall_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_W:0]    hist1,
  input  logic [REG_W:0]    hist2,
  input  logic [REG_W:0]    hist3,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [PERF_W-1:0] stall_cnt
);

  stall_state_e      state_q, state_d;
  logic [1:0]        remain_q, remain_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       w_m1_a, w_m2_a, w_ld1_a;
  logic       w_m1_b, w_m2_b, w_ld1_b;
  logic [1:0] w_n_a, w_n_b, w_n;
  logic       w_stall;

  hazard_match #(.FWD_EN(FWD_EN), .REG_W(REG_W)) u_match_a (
    .src_i    (id_rs),
    .use_i    (id_use_rs),
    .hist1_i  (hist1),
    .hist2_i  (hist2),
    .hist3_i  (hist3),
    .match1_o (w_m1_a),
    .match2_o (w_m2_a),
    .load1_o  (w_ld1_a),
    .fwd_o    (fwd_a)
  );

  hazard_match #(.FWD_EN(FWD_EN), .REG_W(REG_W)) u_match_b (
    .src_i    (id_rt),
    .use_i    (id_use_rt),
    .hist1_i  (hist1),
    .hist2_i  (hist2),
    .hist3_i  (hist3),
    .match1_o (w_m1_b),
    .match2_o (w_m2_b),
    .load1_o  (w_ld1_b),
    .fwd_o    (fwd_b)
  );

  // Without forwarding a producer k stages back needs 3-k bubbles; WB writes through.
  always_comb begin
    w_n_a = 2'd0;
    w_n_b = 2'd0;
    if (FWD_EN != 0) begin
      if (w_m1_a && w_ld1_a) w_n_a = 2'd1;
      if (w_m1_b && w_ld1_b) w_n_b = 2'd1;
    end else begin
      if (w_m1_a)      w_n_a = 2'd2;
      else if (w_m2_a) w_n_a = 2'd1;
      if (w_m1_b)      w_n_b = 2'd2;
      else if (w_m2_b) w_n_b = 2'd1;
    end
    w_n = (w_n_a > w_n_b) ? w_n_a : w_n_b;
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    w_stall  = 1'b0;
    if (flush) begin
      state_d  = ST_IDLE;
      remain_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (id_valid && (w_n != 2'd0)) begin
            w_stall = 1'b1;
            if (w_n >= 2'd2) begin
              state_d  = ST_STALL;
              remain_d = w_n - 2'd1;
            end
          end
        end
        ST_STALL: begin
          w_stall  = 1'b1;
          remain_d = remain_q - 2'd1;
          if (remain_q == 2'd1) state_d = ST_IDLE;
        end
        default: begin
          state_d  = ST_IDLE;
          remain_d = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remain_q    <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Masked in reset so a hazard on the inputs cannot leak a stall through IDLE.
  assign stall     = w_stall && !rst;
  assign bubble    = stall;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_hazard_stall_ctrl: vector table plus multi-cycle stall sequences |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs, id_use_rt, flush;
  logic [4:0]  id_rs, id_rt;
  logic [5:0]  hist1, hist2, hist3;

  logic        stall1, bubble1, stall0, bubble0;
  logic [1:0]  fa1, fb1, fa0, fb0;
  logic [31:0] cnt1, cnt0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.FWD_EN(1), .REG_W(5), .PERF_W(32)) u_dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .hist1(hist1), .hist2(hist2), .hist3(hist3), .flush(flush),
    .stall(stall1), .bubble(bubble1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1)
  );

  hazard_stall_ctrl #(.FWD_EN(0), .REG_W(5), .PERF_W(32)) u_dut_stl (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .hist1(hist1), .hist2(hist2), .hist3(hist3), .flush(flush),
    .stall(stall0), .bubble(bubble0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [5:0] h1;
    logic [5:0] h2;
    logic [5:0] h3;
    logic       s1;
    logic [1:0] a1;
    logic [1:0] b1;
    logic       s0;
    logic [1:0] a0;
    logic [1:0] b0;
  } vec_t;

  typedef struct {
    int         idx;
    logic       s1;
    logic [1:0] a1;
    logic [1:0] b1;
    logic       s0;
    logic [1:0] a0;
    logic [1:0] b0;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt1 = 0;
  logic [31:0] exp_cnt0 = 0;

  function automatic logic [5:0] he(input bit ld, input int dst);
    return {ld, 5'(dst)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [5:0] h1, input logic [5:0] h2, input logic [5:0] h3);
    id_valid  = v;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    hist1     = h1;
    hist2     = h2;
    hist3     = h3;
    flush     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_hist();
    hist3 = hist2;
    hist2 = hist1;
    hist1 = 6'd0;
  endtask

  task automatic flush_cycle();
    step();
    flush = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    exp_t e;

    //          valid rs     rt     urs   urt   h1          h2          h3          s1    a1     b1     s0    a0     b0
    vecs[0]  = '{1'b1, 5'd5,  5'd3,  1'b1, 1'b1, he(0,5),    he(0,9),    he(0,3),    1'b0, 2'b01, 2'b11, 1'b1, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 5'd5,  5'd6,  1'b1, 1'b1, he(1,5),    he(0,6),    6'd0,       1'b1, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00};
    vecs[2]  = '{1'b1, 5'd5,  5'd5,  1'b1, 1'b1, he(0,5),    he(0,5),    6'd0,       1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 2'b00};
    vecs[3]  = '{1'b1, 5'd0,  5'd4,  1'b1, 1'b1, he(1,0),    he(0,0),    he(0,0),    1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00};
    vecs[4]  = '{1'b1, 5'd5,  5'd8,  1'b0, 1'b1, he(1,5),    he(0,1),    he(0,2),    1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{1'b0, 5'd5,  5'd7,  1'b1, 1'b1, he(1,5),    he(0,7),    6'd0,       1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00};
    vecs[6]  = '{1'b1, 5'd9,  5'd10, 1'b1, 1'b1, he(0,1),    he(0,9),    he(0,10),   1'b0, 2'b10, 2'b11, 1'b1, 2'b00, 2'b00};
    vecs[7]  = '{1'b1, 5'd12, 5'd12, 1'b1, 1'b1, he(0,2),    he(0,3),    he(1,12),   1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00};
    vecs[8]  = '{1'b1, 5'd7,  5'd0,  1'b1, 1'b1, he(0,7),    he(0,7),    he(0,7),    1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 2'b00};
    vecs[9]  = '{1'b1, 5'd3,  5'd0,  1'b1, 1'b0, he(0,4),    he(1,3),    6'd0,       1'b0, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00};
    vecs[10] = '{1'b1, 5'd31, 5'd31, 1'b1, 1'b1, he(1,31),   6'd0,       6'd0,       1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00};
    vecs[11] = '{1'b1, 5'd6,  5'd5,  1'b1, 1'b1, he(1,5),    he(0,6),    6'd0,       1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 2'b00};

    // Reset with a live hazard on the inputs: stall must stay low, fwd stays combinational.
    rst = 1'b1;
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, he(0,5), 6'd0, 6'd0);
    #3;
    chk("rst.stall_fwd",  {31'd0, stall1}, 32'd0);
    chk("rst.bubble_fwd", {31'd0, bubble1}, 32'd0);
    chk("rst.stall_stl",  {31'd0, stall0}, 32'd0);
    chk("rst.bubble_stl", {31'd0, bubble0}, 32'd0);
    chk("rst.cnt_fwd",    cnt1, 32'd0);
    chk("rst.cnt_stl",    cnt0, 32'd0);
    chk("rst.fwd_a",      {30'd0, fa1}, 32'd1);
    @(negedge clk);
    id_valid = 1'b0;
    rst      = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step();
      set_in(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
             vecs[i].h1, vecs[i].h2, vecs[i].h3);
      sb.push_back('{i, vecs[i].s1, vecs[i].a1, vecs[i].b1, vecs[i].s0, vecs[i].a0, vecs[i].b0});
      exp_cnt1 += {31'd0, vecs[i].s1};
      exp_cnt0 += {31'd0, vecs[i].s0};
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d.stall_fwd", e.idx),  {31'd0, stall1},  {31'd0, e.s1});
      chk($sformatf("v%0d.bubble_fwd", e.idx), {31'd0, bubble1}, {31'd0, e.s1});
      chk($sformatf("v%0d.fwd_a_fwd", e.idx),  {30'd0, fa1},     {30'd0, e.a1});
      chk($sformatf("v%0d.fwd_b_fwd", e.idx),  {30'd0, fb1},     {30'd0, e.b1});
      chk($sformatf("v%0d.stall_stl", e.idx),  {31'd0, stall0},  {31'd0, e.s0});
      chk($sformatf("v%0d.bubble_stl", e.idx), {31'd0, bubble0}, {31'd0, e.s0});
      chk($sformatf("v%0d.fwd_a_stl", e.idx),  {30'd0, fa0},     {30'd0, e.a0});
      chk($sformatf("v%0d.fwd_b_stl", e.idx),  {30'd0, fb0},     {30'd0, e.b0});
      flush_cycle();
    end
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    chk("table.cnt_fwd", cnt1, exp_cnt1);
    chk("table.cnt_stl", cnt0, exp_cnt0);

    // Load-use with forwarding: one bubble, then the load is picked up from MEM.
    step();
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, he(1,5), 6'd0, 6'd0);
    @(negedge clk);
    chk("lu.c1.stall", {31'd0, stall1}, 32'd1);
    chk("lu.c1.bubble", {31'd0, bubble1}, 32'd1);
    chk("lu.c1.fwd_a", {30'd0, fa1}, 32'd0);
    exp_cnt1 += 1;
    exp_cnt0 += 1;
    step();
    shift_hist();
    @(negedge clk);
    chk("lu.c2.stall", {31'd0, stall1}, 32'd0);
    chk("lu.c2.fwd_a", {30'd0, fa1}, 32'd2);
    chk("lu.c2.stl_held", {31'd0, stall0}, 32'd1);
    exp_cnt0 += 1;
    chk("lu.cnt_fwd", cnt1, exp_cnt1);
    flush_cycle();

    // No forwarding, EX producer: exactly two stall cycles.
    step();
    set_in(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, he(0,7), 6'd0, 6'd0);
    @(negedge clk);
    chk("nf.c1.stall", {31'd0, stall0}, 32'd1);
    chk("nf.c1.fwd_stall", {31'd0, stall1}, 32'd0);
    exp_cnt0 += 1;
    step();
    shift_hist();
    @(negedge clk);
    chk("nf.c2.stall", {31'd0, stall0}, 32'd1);
    chk("nf.c2.fwd_b", {30'd0, fb1}, 32'd2);
    exp_cnt0 += 1;
    step();
    shift_hist();
    @(negedge clk);
    chk("nf.c3.stall", {31'd0, stall0}, 32'd0);
    chk("nf.cnt_stl", cnt0, exp_cnt0);
    flush_cycle();

    // Flush arriving in the first STALL cycle.
    step();
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, he(0,5), 6'd0, 6'd0);
    @(negedge clk);
    chk("fl.c1.stall", {31'd0, stall0}, 32'd1);
    exp_cnt0 += 1;
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fl.c2.stall", {31'd0, stall0}, 32'd0);
    chk("fl.c2.bubble", {31'd0, bubble0}, 32'd0);
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    chk("fl.c3.idle", {31'd0, stall0}, 32'd0);
    chk("fl.cnt_stl", cnt0, exp_cnt0);
    flush_cycle();

    // Saturation, then an asynchronous reset in the middle of a STALL.
    step();
    flush = 1'b0;
    #2;
    force u_dut_fwd.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut_fwd.stall_cnt_q;
    step();
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, he(1,5), 6'd0, 6'd0);
    @(negedge clk);
    chk("sat.stall", {31'd0, stall1}, 32'd1);
    step();
    shift_hist();
    @(negedge clk);
    chk("sat.cnt_fwd", cnt1, 32'hFFFF_FFFF);
    chk("ar.pre_stall", {31'd0, stall0}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar.stall_stl", {31'd0, stall0}, 32'd0);
    chk("ar.bubble_stl", {31'd0, bubble0}, 32'd0);
    chk("ar.cnt_stl", cnt0, 32'd0);
    chk("ar.cnt_fwd", cnt1, 32'd0);
    chk("ar.fwd_a", {30'd0, fa1}, 32'd2);
    id_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar.idle_after", {31'd0, stall0}, 32'd0);
    chk("ar.cnt_after", cnt0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
